// File: rtl/race_pkg.sv
// +----------------------------------------------------------------------+
// | race_pkg : shared ids, frame limit, state type and helpers for the   |
// |            three-animal race scheduler.                              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package race_pkg;

    localparam logic [1:0] ID_CAT     = 2'b00;
    localparam logic [1:0] ID_DOG     = 2'b01;
    localparam logic [1:0] ID_MOUSE   = 2'b10;
    localparam logic [1:0] FRAME_LAST = 2'd3;

    typedef enum logic [2:0] {
        INIT_CAT   = 3'd0,
        INIT_DOG   = 3'd1,
        INIT_MOUSE = 3'd2,
        ARB        = 3'd3,
        HOLD       = 3'd4,
        WIN        = 3'd5
    } state_t;

    // Round-robin successor: cat -> dog -> mouse -> cat (unused id 3 maps to cat).
    function automatic logic [1:0] next_id(input logic [1:0] id);
        case (id)
            ID_CAT:  next_id = ID_DOG;
            ID_DOG:  next_id = ID_MOUSE;
            default: next_id = ID_CAT;
        endcase
    endfunction

    function automatic logic [1:0] sat_inc(input logic [1:0] frame);
        sat_inc = (frame == FRAME_LAST) ? FRAME_LAST : frame + 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb3.sv
// +----------------------------------------------------------------------+
// | rr_arb3 : combinational 3-way round-robin arbiter; search starts at  |
// |           the animal after 'last'.                                   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_arb3
    import race_pkg::*;
(
    input  logic [2:0] pending,
    input  logic [1:0] last,
    output logic [2:0] gnt_onehot,
    output logic [1:0] gnt_id,
    output logic       any
);

    logic [3:0] w_pend4;
    logic [1:0] w_cand;
    logic       w_found;

    always_comb begin
        w_pend4    = {1'b0, pending};
        w_cand     = next_id(last);
        w_found    = 1'b0;
        gnt_id     = ID_CAT;
        gnt_onehot = '0;
        for (int k = 0; k < 3; k++) begin
            if (!w_found && w_pend4[w_cand]) begin
                w_found = 1'b1;
                gnt_id  = w_cand;
            end
            w_cand = next_id(w_cand);
        end
        any = w_found;
        if (w_found) begin
            gnt_onehot = 3'(4'b0001 << gnt_id);
        end
    end

endmodule

`default_nettype wire

// File: rtl/race_scheduler.sv
// +----------------------------------------------------------------------+
// | race_scheduler : sequences the race display mode word, arbitrates    |
// |                  advance requests, tracks positions and the winner.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module race_scheduler
    import race_pkg::*;
#(
    parameter int HOLD_TICKS = 1000,
    parameter int CW         = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       start,
    output logic [3:0] mode,
    output logic [2:0] grant,
    output logic [5:0] pos,
    output logic [1:0] winner,
    output logic       win_valid,
    output logic       busy
);

    localparam logic [CW-1:0] c_hold_last = CW'(HOLD_TICKS - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_req_q;
    logic [2:0]      r_pending;
    logic [1:0]      r_last;
    logic [3:0]      r_mode;
    logic [2:0]      r_grant;
    logic [2:0][1:0] r_pos;
    logic [1:0]      r_winner;
    logic            r_win_valid;

    logic [2:0]      w_rise;
    logic [2:0]      w_gnt_onehot;
    logic [1:0]      w_gnt_id;
    logic            w_any;
    logic            w_busy;
    logic            w_cnt_done;
    logic [1:0]      w_pos_gnt;
    logic [1:0]      w_pos_last;

    assign w_rise     = req & ~r_req_q;
    assign w_busy     = (r_state != ARB) && (r_state != WIN);
    assign w_cnt_done = (r_cnt == c_hold_last);

    rr_arb3 u_arb (
        .pending    (r_pending),
        .last       (r_last),
        .gnt_onehot (w_gnt_onehot),
        .gnt_id     (w_gnt_id),
        .any        (w_any)
    );

    always_comb begin
        w_pos_gnt  = r_pos[2];
        w_pos_last = r_pos[2];
        case (w_gnt_id)
            ID_CAT:  w_pos_gnt = r_pos[0];
            ID_DOG:  w_pos_gnt = r_pos[1];
            default: w_pos_gnt = r_pos[2];
        endcase
        case (r_last)
            ID_CAT:  w_pos_last = r_pos[0];
            ID_DOG:  w_pos_last = r_pos[1];
            default: w_pos_last = r_pos[2];
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            INIT_CAT:   if (w_cnt_done) w_state_nxt = INIT_DOG;
            INIT_DOG:   if (w_cnt_done) w_state_nxt = INIT_MOUSE;
            INIT_MOUSE: if (w_cnt_done) w_state_nxt = ARB;
            ARB:        if (w_any)      w_state_nxt = HOLD;
            HOLD: begin
                if (w_cnt_done) begin
                    w_state_nxt = (w_pos_last == FRAME_LAST) ? WIN : ARB;
                end
            end
            WIN:        if (start)      w_state_nxt = INIT_CAT;
            default:                    w_state_nxt = INIT_CAT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= INIT_CAT;
            r_cnt       <= '0;
            r_req_q     <= req;
            r_pending   <= '0;
            r_last      <= ID_MOUSE;
            r_mode      <= 4'b0000;
            r_grant     <= '0;
            r_pos       <= '0;
            r_winner    <= ID_CAT;
            r_win_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_req_q <= req;
            r_grant <= '0;
            if (w_busy) begin
                r_cnt <= w_cnt_done ? '0 : r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
            case (r_state)
                INIT_CAT: begin
                    r_pending <= '0;
                    if (w_cnt_done) r_mode <= {ID_DOG, 2'b00};
                end
                INIT_DOG: begin
                    r_pending <= '0;
                    if (w_cnt_done) r_mode <= {ID_MOUSE, 2'b00};
                end
                ARB: begin
                    // A rise on the grant edge re-queues the same animal.
                    r_pending <= (r_pending & ~w_gnt_onehot) | w_rise;
                    if (w_any) begin
                        for (int i = 0; i < 3; i++) begin
                            if (w_gnt_onehot[i]) r_pos[i] <= sat_inc(r_pos[i]);
                        end
                        r_mode  <= {w_gnt_id, sat_inc(w_pos_gnt)};
                        r_grant <= w_gnt_onehot;
                        r_last  <= w_gnt_id;
                    end
                end
                HOLD: begin
                    r_pending <= r_pending | w_rise;
                    if (w_cnt_done && (w_pos_last == FRAME_LAST)) begin
                        r_winner    <= r_last;
                        r_win_valid <= 1'b1;
                    end
                end
                WIN: begin
                    r_pending <= '0;
                    if (start) begin
                        r_win_valid <= 1'b0;
                        r_pos       <= '0;
                        r_mode      <= {ID_CAT, 2'b00};
                    end
                end
                default: r_pending <= '0;
            endcase
        end
    end

    assign mode      = r_mode;
    assign grant     = r_grant;
    assign pos       = r_pos;
    assign winner    = r_winner;
    assign win_valid = r_win_valid;
    assign busy      = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_race_scheduler.sv
// +----------------------------------------------------------------------+
// | tb_race_scheduler : randomized scoreboard bench for race_scheduler.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_race_scheduler;

    localparam int HT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic       start;
    logic [3:0] mode;
    logic [2:0] grant;
    logic [5:0] pos;
    logic [1:0] winner;
    logic       win_valid;
    logic       busy;

    race_scheduler #(.HOLD_TICKS(HT), .CW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .start     (start),
        .mode      (mode),
        .grant     (grant),
        .pos       (pos),
        .winner    (winner),
        .win_valid (win_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] g;
        logic [3:0] m;
        logic [5:0] p;
        int         c;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;

    // Reference model: positions, last granted id, win status.
    int mpos[3];
    int mlast;
    bit won;
    int mwin;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [5:0] packpos();
        return {2'(mpos[2]), 2'(mpos[1]), 2'(mpos[0])};
    endfunction

    function automatic int pick(input logic [2:0] pend);
        int id;
        id = (mlast + 1) % 3;
        for (int s = 0; s < 3; s++) begin
            if (pend[id]) return id;
            id = (id + 1) % 3;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) mpos[i] = 0;
        mlast = 2;
        won   = 1'b0;
    endfunction

    always @(negedge clk) begin
        if (mon_en && grant !== 3'b000) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_grant: got grant %b mode %b, expected none (cycle %0d)", grant, mode, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("grant", 32'(grant), 32'(e.g));
                chk("grant_mode", 32'(mode), 32'(e.m));
                chk("grant_pos", 32'(pos), 32'(e.p));
                chk("grant_cycle", cyc, e.c);
            end
        end
    end

    // Called at the negedge just after a reset or start edge.
    task automatic check_init();
        chk("init_pos", 32'(pos), 0);
        chk("init_win_valid", 32'(win_valid), 0);
        chk("init_grant", 32'(grant), 0);
        for (int i = 0; i < 13; i++) begin
            chk("init_mode", 32'(mode), (i < 4) ? 32'h0 : (i < 8) ? 32'h4 : 32'h8);
            chk("init_busy", 32'(busy), (i < 12) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic burst(input logic [2:0] mask, input bit rr, input int rk, input int ra);
        int         n, base, k, id, lastc;
        logic [2:0] pend;
        bit         applied;
        exp_t       e;
        n       = cyc;
        base    = n + 2;
        pend    = mask;
        k       = 0;
        applied = 1'b0;
        lastc   = n;
        while (pend != 3'b000 && !won) begin
            id = pick(pend);
            mpos[id]++;
            mlast    = id;
            pend[id] = 1'b0;
            e.g = 3'(3'b001 << id);
            e.m = {2'(id), 2'(mpos[id])};
            e.p = packpos();
            e.c = base + 5 * k;
            exp_q.push_back(e);
            lastc = e.c;
            if (rr && k == rk) begin
                pend[ra] = 1'b1;
                applied  = 1'b1;
            end
            if (mpos[id] == 3) begin
                won  = 1'b1;
                mwin = id;
            end
            k++;
        end
        req = mask;
        @(negedge clk);
        req = 3'b000;
        if (applied) begin
            while (cyc < base + 5 * rk - 1) @(negedge clk);
            req[ra] = 1'b1;
            @(negedge clk);
            req = 3'b000;
        end
        while (cyc < lastc + 6) @(negedge clk);
    endtask

    task automatic win_seq();
        chk("win_valid", 32'(win_valid), 1);
        chk("winner", 32'(winner), mwin);
        chk("win_mode", 32'(mode), {mwin[1:0], 2'b11});
        chk("win_busy", 32'(busy), 0);
        chk("win_pos", 32'(pos), 32'(packpos()));
        req = 3'b111;
        @(negedge clk);
        req = 3'b000;
        repeat (8) @(negedge clk);
        chk("win_hold_valid", 32'(win_valid), 1);
        chk("win_hold_mode", 32'(mode), {mwin[1:0], 2'b11});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) mpos[i] = 0;
        won = 1'b0;
        check_init();
    endtask

    task automatic reset_mid_hold();
        int   n, id;
        exp_t e;
        n  = cyc;
        id = pick(3'b111);
        mpos[id]++;
        e.g = 3'(3'b001 << id);
        e.m = {2'(id), 2'(mpos[id])};
        e.p = packpos();
        e.c = n + 2;
        exp_q.push_back(e);
        req = 3'b111;
        @(negedge clk);
        req = 3'b000;
        while (cyc < n + 4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        model_reset();
        check_init();
        repeat (10) @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        req   = 3'b000;
        start = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        check_init();

        // All three at once with dog re-rising on its own grant edge.
        burst(3'b111, 1'b1, 1, 1);
        burst(3'b001, 1'b0, 0, 0);
        burst(3'b001, 1'b0, 0, 0);
        chk("directed_won", 32'(won), 1);
        if (won) win_seq();

        reset_mid_hold();

        for (int it = 0; it < 16; it++) begin
            if (won) win_seq();
            burst(3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(1, 3)), int'($urandom_range(0, 2)));
        end
        if (won) win_seq();

        repeat (4) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/race_scheduler.md
Name: race_scheduler

Overview:
- Sequences the three-animal dot-matrix race display by generating the 4-bit mode word consumed by the animation/frame-select logic (mode[3:2] = animal, mode[1:0] = frame).
- Three requesters (cat, dog, mouse advance buttons) share that single mode bus, so a round-robin arbiter decides which animal's update goes out next.
- Each mode value is held long enough for the downstream 1 Hz frame sampler to capture it.
- The block also tracks each animal's position, detects the winner, and runs the start/restart sequence.

Parameters:
- HOLD_TICKS, 1000: clk cycles each issued mode value is held. 1000 = one 1 Hz period at 1 kHz.
- CW, 10: hold-counter width. Must satisfy 2^CW >= HOLD_TICKS.

Ports:
- clk: input, 1. Scan-domain clock (1 kHz in system).
- rst: input, 1. Synchronous reset, active-high.
- req: input, 3. Advance requests as levels; bit0 cat, bit1 dog, bit2 mouse. Rising edges are detected internally.
- start: input, 1. Restart pulse; honoured only in WIN.
- mode: output, 4. Mode word to the display chain; {animal_id[1:0], frame[1:0]}.
- grant: output, 3. One-hot, one-cycle pulse marking the animal just issued.
- pos: output, 6. Current frame per animal; {mouse[1:0], dog[1:0], cat[1:0]}.
- winner: output, 2. Animal id of the winner; valid only while win_valid = 1.
- win_valid: output, 1. High in WIN.
- busy: output, 1. High in any INIT or HOLD state.

Behaviour:
- Animal ids: cat = 2'b00, dog = 2'b01, mouse = 2'b10. Id 2'b11 is never emitted.
- Reset values, at the first clk edge with rst = 1:
  - mode = 4'b0000, grant = 0, pos = 0, winner = 0, win_valid = 0, busy = 1.
  - pending = 0, last_grant = mouse, hold counter = 0.
  - state = INIT_CAT.
  - rst asserted in any state, mid-hold included, aborts immediately with the same values.
- Edge detect:
  - req_q is a registered copy of req. rise = req & ~req_q.
  - req_q resets to the current req value, so a button held through reset does not fire.
- Pending: pending[i] is set by rise[i] and cleared when animal i is granted. If both happen on the same edge, set wins.
- INIT_CAT:
  - mode = 0000. Hold HOLD_TICKS cycles, then go to INIT_DOG.
- INIT_DOG:
  - mode = 0100. Hold HOLD_TICKS cycles, then go to INIT_MOUSE.
- INIT_MOUSE:
  - mode = 1000. Hold HOLD_TICKS cycles, then go to ARB.
  - pos = 0 throughout INIT.
  - pending is cleared during INIT; rises are ignored.
- ARB:
  - If pending = 0: stay in ARB; mode keeps its last value.
  - Otherwise pick the first pending animal in round-robin order, starting after last_grant.
  - On that edge:
    - pos[i] <= pos[i] + 1.
    - mode <= {id, pos[i] + 1}.
    - grant[i] <= 1 for one cycle.
    - last_grant <= i.
    - Go to HOLD.
- HOLD:
  - Counter runs 0 to HOLD_TICKS-1 with mode stable.
  - On the count HOLD_TICKS-1: if pos[last_grant] == 3, set winner = last_grant, win_valid = 1 and go to WIN; otherwise go to ARB.
  - Rises during HOLD are queued in pending.
- WIN:
  - mode holds the final frame, e.g. 0011 for cat.
  - pending is cleared; rises are ignored.
  - start = 1 clears win_valid and pos, and goes to INIT_CAT.
- Position arithmetic:
  - 2-bit, saturating at 3.
  - ARB cannot grant an animal at 3, because WIN is entered first.
- Minimum issue spacing is HOLD_TICKS + 1 cycles: one ARB cycle plus the hold.

Decomposition:
- race_pkg holds:
  - ID_CAT, ID_DOG, ID_MOUSE.
  - FRAME_LAST = 2'd3.
  - The state enum: INIT_CAT, INIT_DOG, INIT_MOUSE, ARB, HOLD, WIN.
- Sub-module rr_arb3: 3-way round-robin arbiter.
  - Inputs: pending[2:0], last[1:0].
  - Outputs: gnt_onehot, gnt_id, any.
  - Purely combinational.
  - Unit-tested separately.

Test Plan (HOLD_TICKS = 4):
- Reset release: mode is 0000 for 4 cycles, then 0100 for 4, then 1000 for 4. State reaches ARB. busy drops. pos = 0.
- Single cat rise in ARB: next edge mode = 0001, grant = 001 for 1 cycle, pos = 000001. mode stable 4 cycles, then back to ARB.
- Simultaneous rises on all three in ARB (last_grant = mouse): grants issue in order cat, dog, mouse. mode sequence is 0001, 0101, 1001, each spaced 5 cycles.
- Dog rise re-asserted on the same edge dog is granted: pending[1] stays 1. Dog is granted again after cat and mouse (if they are pending) or immediately on the next ARB.
- Cat advanced three times, dog once: after the third cat hold, win_valid = 1, winner = 00, mode = 0011. Further req rises change nothing. start pulse leads to mode 0000 with pos = 0.
- rst asserted at HOLD cycle 2: next edge gives mode = 0000, pos = 0, grant = 0, state INIT_CAT. Any pending request is lost.
